// File: rtl/ysyx_22041752_dsram_responder.sv
// ysyx_22041752_dsram_responder: fixed-latency single-beat SRAM responder backing the D-cache miss/writeback port
module ysyx_22041752_dsram_responder #(
    parameter int ADDR_WD    = 32,
    parameter int DATA_WD    = 64,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sram_req,
    input  logic               sram_wen,
    input  logic [ADDR_WD-1:0] sram_addr,
    input  logic [DATA_WD-1:0] sram_wdata,
    output logic               sram_ready,
    output logic               sram_valid,
    output logic [DATA_WD-1:0] sram_rdata,
    output logic               busy
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WAIT, S_RESP} state_t;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wen_q, wen_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [DATA_WD-1:0]    wdata_q, wdata_d;
    logic [DATA_WD-1:0]    rdata_q, rdata_d;
    logic [DATA_WD-1:0]    mem [2**DEPTH_LOG2];
    logic                  unused_addr;
    assign unused_addr = ^{sram_addr[ADDR_WD-1:DEPTH_LOG2+3], sram_addr[2:0]};
    assign sram_ready  = state_q == S_ACCEPT;
    assign sram_valid  = state_q == S_RESP;
    assign busy        = state_q != S_IDLE;
    assign sram_rdata  = rdata_q;
    // next-state, request capture, latency countdown and read-data staging
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: if (sram_req) begin
                state_d = S_ACCEPT;
                wen_d   = sram_wen;
                idx_d   = sram_addr[DEPTH_LOG2+2:3];
                wdata_d = sram_wdata;
            end
            S_ACCEPT: begin
                cnt_d   = CW'(LATENCY - 1);
                state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? S_RESP : S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
        rdata_d = (state_d == S_RESP && state_q != S_RESP && !wen_q) ? mem[idx_q] : rdata_q;
    end
    // control and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    // write lands on the edge that ends RESP; a reset at that edge cancels it
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_RESP && wen_q) mem[idx_q] <= wdata_q;
    end
endmodule

// File: tb/tb_ysyx_22041752_dsram_responder.sv
// tb_ysyx_22041752_dsram_responder: randomized and directed checks against a word-array reference model
module tb_ysyx_22041752_dsram_responder;
    logic        clk = 0, reset = 1;
    logic        req = 0, wen = 0;
    logic [31:0] addr = 0;
    logic [63:0] wdata = 0;
    logic        ready, valid, busy;
    logic [63:0] rdata;
    logic        reqb = 0, wenb = 0;
    logic [31:0] addrb = 0;
    logic [63:0] wdatab = 0;
    logic        readyb, validb, busyb;
    logic [63:0] rdatab;
    int          errors = 0, checks = 0;
    int          cyc = 0, nready = 0, nvalid = 0;
    int          rq_b[$], vq_b[$];
    logic [63:0] model [int];
    logic [63:0] last_rd = 0;
    int          written[$];

    ysyx_22041752_dsram_responder #(.LATENCY(4)) dut_a (
        .clk(clk), .reset(reset), .sram_req(req), .sram_wen(wen), .sram_addr(addr),
        .sram_wdata(wdata), .sram_ready(ready), .sram_valid(valid), .sram_rdata(rdata), .busy(busy));
    ysyx_22041752_dsram_responder #(.LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .sram_req(reqb), .sram_wen(wenb), .sram_addr(addrb),
        .sram_wdata(wdatab), .sram_ready(readyb), .sram_valid(validb), .sram_rdata(rdatab), .busy(busyb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (ready) nready++;
        if (valid) nvalid++;
        if (readyb) rq_b.push_back(cyc);
        if (validb) vq_b.push_back(cyc);
    end

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 8) % 1024);
    endfunction

    task automatic txn(input bit w, input logic [31:0] a, input logic [63:0] d, input string nm);
        int n;
        logic [63:0] exp;
        @(negedge clk);
        req = 1; wen = w; addr = a; wdata = d;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", nm, ready); end
        req = 0; wen = 0; addr = $urandom; wdata = {$urandom, $urandom};
        n = 0;
        while (valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL %s latency: got %0d want 4", nm, n); end
        if (w) begin
            model[word_of(a)] = d;
            written.push_back(word_of(a));
            exp = last_rd;
        end else begin
            exp = model.exists(word_of(a)) ? model[word_of(a)] : 64'hx;
            last_rd = exp;
        end
        checks++;
        if (rdata !== exp) begin errors++; $display("FAIL %s rdata: got %h want %h", nm, rdata, exp); end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || rdata !== exp) begin
            errors++; $display("FAIL %s after: valid=%b busy=%b rdata=%h want 0 0 %h", nm, valid, busy, rdata, exp);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready, valid, busy, readyb, validb, busyb} !== 6'b0 || rdata !== 64'h0 || rdatab !== 64'h0) begin
            errors++; $display("FAIL reset: ready=%b valid=%b busy=%b rdata=%h want all 0", ready, valid, busy, rdata);
        end
        reset = 0;
    endtask

    task automatic test_write_read;
        txn(1, 32'h8000_0040, 64'hDEAD_BEEF_0123_4567, "wr_basic");
        txn(0, 32'h8000_0040, 64'h0, "rd_basic");
    endtask

    task automatic test_offset;
        txn(1, 32'h100, 64'h0BAD_F00D_CAFE_0100, "wr_off");
        txn(0, 32'h104, 64'h0, "rd_off4");
        txn(0, 32'h107, 64'h0, "rd_off7");
    endtask

    task automatic test_line;
        int r0, v0;
        r0 = nready; v0 = nvalid;
        txn(1, 32'h200, 64'h1111, "line_w0");
        txn(1, 32'h208, 64'h2222, "line_w1");
        txn(0, 32'h200, 64'h0, "line_r0");
        txn(0, 32'h208, 64'h0, "line_r1");
        checks++;
        if (nready - r0 !== 4 || nvalid - v0 !== 4) begin
            errors++; $display("FAIL line pulses: ready=%0d valid=%0d want 4 4", nready - r0, nvalid - v0);
        end
    endtask

    task automatic test_held_req;
        rq_b.delete(); vq_b.delete();
        @(negedge clk);
        reqb = 1; wenb = 1; addrb = 32'h40; wdatab = 64'h77;
        repeat (12) @(negedge clk);
        reqb = 0;
        repeat (6) @(negedge clk);
        checks++;
        if (rq_b.size() !== 4 || vq_b.size() !== 4) begin
            errors++; $display("FAIL held count: ready=%0d valid=%0d want 4 4", rq_b.size(), vq_b.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (vq_b[i] - rq_b[i] !== 1 || (i > 0 && rq_b[i] - rq_b[i-1] !== 3)) begin
                    errors++; $display("FAIL held txn%0d: ready@%0d valid@%0d", i, rq_b[i], vq_b[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        txn(1, 32'h300, 64'h5555, "mid_pre");
        @(negedge clk);
        req = 1; wen = 1; addr = 32'h300; wdata = 64'hAAAA;
        @(negedge clk);
        req = 0; wen = 0;
        @(negedge clk);
        v0 = nvalid;
        reset = 1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rdata !== 64'h0) begin
            errors++; $display("FAIL mid busy/rdata: got %b %h want 0 0", busy, rdata);
        end
        reset = 0;
        last_rd = 0;
        repeat (6) @(negedge clk);
        checks++;
        if (nvalid !== v0) begin errors++; $display("FAIL mid valid: got %0d pulses want 0", nvalid - v0); end
        txn(0, 32'h300, 64'h0, "mid_rd");
    endtask

    task automatic test_alias;
        txn(1, 32'h0000_2010, 64'hA11A_5000_0000_2010, "alias_wr");
        txn(0, 32'h0000_0010, 64'h0, "alias_rd");
    endtask

    task automatic test_random;
        int idx;
        logic [31:0] a;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1 || written.size() == 0) begin
                a = ($urandom & 32'hFFFF_E000) | ($urandom_range(0, 1023) * 8) | $urandom_range(0, 7);
                txn(1, a, {$urandom, $urandom}, "rand_wr");
            end else begin
                idx = written[$urandom_range(0, written.size() - 1)];
                a = ($urandom & 32'hFFFF_E000) | (idx * 8) | $urandom_range(0, 7);
                txn(0, a, 64'h0, "rand_rd");
            end
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_offset;
        test_line;
        test_held_req;
        test_reset_mid;
        test_alias;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
